// File: rtl/float_sub16_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : float_sub16_pipe                                           |
// | Description : Pipelined IEEE-754 half-precision subtractor,              |
// |               out_diff = in_a - in_b. Subnormals are flushed to zero.    |
// |               The result is truncated unless FLOAT_SUB16_RNE_EN is       |
// |               defined, in which case it is rounded to nearest-even.      |
// |               Valid/ready on both sides; a stall freezes every stage.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module float_sub16_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_diff
);

    localparam logic [15:0] C_QNAN    = 16'h7E00;
    localparam logic [4:0]  C_EXP_MAX = 5'h1F;
`ifdef FLOAT_SUB16_RNE_EN
    localparam int          C_NORM_LSB = 0;   // keep guard/round/sticky for rounding
`else
    localparam int          C_NORM_LSB = 3;   // truncation drops guard/round/sticky
`endif

    // Whole pipeline advances together; a held output freezes every stage.
    logic w_adv;
    assign w_adv    = !(out_valid && !out_ready);
    assign in_ready = w_adv;

    // ---------------- stage 1: unpack, classify, order by magnitude --------
    logic        w1_b_sign;
    logic        w1_a_zero, w1_b_zero;
    logic        w1_a_nan, w1_b_nan, w1_a_inf, w1_b_inf;
    logic [10:0] w1_a_sig, w1_b_sig;
    logic [14:0] w1_a_mag, w1_b_mag;
    logic        w1_spec;
    logic [15:0] w1_spec_val;
    logic        w1_sign_l, w1_sign_s;
    logic [4:0]  w1_exp_l, w1_exp_s;
    logic [10:0] w1_sig_l, w1_sig_s;

    logic        r1_valid, r1_spec, r1_sign_l, r1_eff_sub;
    logic [15:0] r1_spec_val;
    logic [4:0]  r1_exp_l, r1_ediff;
    logic [10:0] r1_sig_l, r1_sig_s;

    // Subtraction becomes addition of a sign-flipped subtrahend.
    always_comb begin
        w1_b_sign = ~in_b[15];
        w1_a_zero = (in_a[14:10] == 5'd0);
        w1_b_zero = (in_b[14:10] == 5'd0);
        w1_a_nan  = (in_a[14:10] == C_EXP_MAX) && (in_a[9:0] != 10'd0);
        w1_b_nan  = (in_b[14:10] == C_EXP_MAX) && (in_b[9:0] != 10'd0);
        w1_a_inf  = (in_a[14:10] == C_EXP_MAX) && (in_a[9:0] == 10'd0);
        w1_b_inf  = (in_b[14:10] == C_EXP_MAX) && (in_b[9:0] == 10'd0);
        w1_a_sig  = w1_a_zero ? 11'd0 : {1'b1, in_a[9:0]};
        w1_b_sig  = w1_b_zero ? 11'd0 : {1'b1, in_b[9:0]};
        w1_a_mag  = w1_a_zero ? 15'd0 : in_a[14:0];
        w1_b_mag  = w1_b_zero ? 15'd0 : in_b[14:0];

        w1_spec     = 1'b1;
        w1_spec_val = C_QNAN;
        if (w1_a_nan || w1_b_nan) begin
            w1_spec_val = C_QNAN;
        end else if (w1_a_inf && w1_b_inf) begin
            // Opposing infinities after the sign flip have no defined difference.
            w1_spec_val = (in_a[15] == w1_b_sign) ? {in_a[15], C_EXP_MAX, 10'd0} : C_QNAN;
        end else if (w1_a_inf) begin
            w1_spec_val = {in_a[15], C_EXP_MAX, 10'd0};
        end else if (w1_b_inf) begin
            w1_spec_val = {w1_b_sign, C_EXP_MAX, 10'd0};
        end else begin
            w1_spec = 1'b0;
        end

        if (w1_a_mag >= w1_b_mag) begin
            w1_sign_l = in_a[15];   w1_exp_l = in_a[14:10]; w1_sig_l = w1_a_sig;
            w1_sign_s = w1_b_sign;  w1_exp_s = in_b[14:10]; w1_sig_s = w1_b_sig;
        end else begin
            w1_sign_l = w1_b_sign;  w1_exp_l = in_b[14:10]; w1_sig_l = w1_b_sig;
            w1_sign_s = in_a[15];   w1_exp_s = in_a[14:10]; w1_sig_s = w1_a_sig;
        end
    end

    // Stage 1 register: ordered operands and exponent distance.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r1_spec     <= w1_spec;
            r1_spec_val <= w1_spec_val;
            r1_sign_l   <= w1_sign_l;
            r1_eff_sub  <= (w1_sign_l != w1_sign_s);
            r1_exp_l    <= w1_exp_l;
            r1_ediff    <= w1_exp_l - w1_exp_s;
            r1_sig_l    <= w1_sig_l;
            r1_sig_s    <= w1_sig_s;
        end
    end

    // ---------------- stage 2: align and add/subtract ----------------------
    logic [13:0] w2_l_full, w2_s_full, w2_s_aln, w2_s_grs;
    logic        w2_sticky;
    logic [14:0] w2_sum;

    logic        r2_valid, r2_spec, r2_sign;
    logic [15:0] r2_spec_val;
    logic [4:0]  r2_exp;
    logic [14:0] r2_sum;

    // Bits shifted past the field collapse into the sticky LSB.
    always_comb begin
        w2_l_full = {r1_sig_l, 3'b000};
        w2_s_full = {r1_sig_s, 3'b000};
        if (r1_ediff >= 5'd14) begin
            w2_s_aln  = 14'd0;
            w2_sticky = |r1_sig_s;
        end else begin
            w2_s_aln  = w2_s_full >> r1_ediff;
            w2_sticky = |(w2_s_full & ((14'd1 << r1_ediff) - 14'd1));
        end
        w2_s_grs = {w2_s_aln[13:1], w2_s_aln[0] | w2_sticky};
        // Larger magnitude is first, so the difference never goes negative.
        if (r1_eff_sub) begin
            w2_sum = {1'b0, w2_l_full} - {1'b0, w2_s_grs};
        end else begin
            w2_sum = {1'b0, w2_l_full} + {1'b0, w2_s_grs};
        end
    end

    // Stage 2 register: raw sum with sign and exponent of the larger operand.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r2_spec     <= r1_spec;
            r2_spec_val <= r1_spec_val;
            r2_sign     <= r1_sign_l;
            r2_exp      <= r1_exp_l;
            r2_sum      <= w2_sum;
        end
    end

    // ---------------- stage 3: normalize -----------------------------------
    logic [3:0]        w3_lzc;
    logic [13:0]       w3_norm;
    logic signed [6:0] w3_exp;

    logic                    r3_valid, r3_spec, r3_sign, r3_zero;
    logic [15:0]             r3_spec_val;
    logic signed [6:0]       r3_exp;
    logic [12:C_NORM_LSB]    r3_norm;

    // Carry shifts right once; otherwise bring the leading one up to bit 13.
    always_comb begin
        w3_lzc = 4'd0;
        for (int i = 0; i < 14; i++) begin
            if (r2_sum[i]) w3_lzc = 4'(13 - i);
        end
        if (r2_sum[14]) begin
            w3_norm = {r2_sum[14:2], r2_sum[1] | r2_sum[0]};
            w3_exp  = $signed({2'b00, r2_exp}) + 7'sd1;
        end else begin
            w3_norm = r2_sum[13:0] << w3_lzc;
            w3_exp  = $signed({2'b00, r2_exp}) - $signed({3'b000, w3_lzc});
        end
    end

    // Stage 3 register: normalized fraction (hidden bit implied) and exponent.
    always_ff @(posedge clk) begin
        if (w_adv) begin
            r3_spec     <= r2_spec;
            r3_spec_val <= r2_spec_val;
            r3_sign     <= r2_sign;
            r3_zero     <= (w3_norm == 14'd0);
            r3_exp      <= w3_exp;
            r3_norm     <= w3_norm[12:C_NORM_LSB];
        end
    end

    // ---------------- output: round (optional) and pack --------------------
    logic signed [6:0] w4_exp;
    logic [9:0]        w4_mant;
    logic [15:0]       w4_res;
`ifdef FLOAT_SUB16_RNE_EN
    logic              w4_rnd_up;
    logic [11:0]       w4_sig_r;
`endif

    // Specials win; tiny results flush to +0, large ones saturate to infinity.
    always_comb begin
        w4_exp  = r3_exp;
        w4_mant = r3_norm[12:3];
`ifdef FLOAT_SUB16_RNE_EN
        w4_rnd_up = r3_norm[2] & (r3_norm[1] | r3_norm[0] | r3_norm[3]);
        w4_sig_r  = {2'b01, r3_norm[12:3]} + {11'd0, w4_rnd_up};
        if (w4_sig_r[11]) begin
            w4_exp  = r3_exp + 7'sd1;
            w4_mant = 10'd0;
        end else begin
            w4_mant = w4_sig_r[9:0];
        end
`endif
        if (r3_spec) begin
            w4_res = r3_spec_val;
        end else if (r3_zero || (r3_exp <= 7'sd0)) begin
            w4_res = 16'h0000;
        end else if (w4_exp >= 7'sd31) begin
            w4_res = {r3_sign, C_EXP_MAX, 10'd0};
        end else begin
            w4_res = {r3_sign, w4_exp[4:0], w4_mant};
        end
    end

    // Valid bits march with the data; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r1_valid  <= 1'b0;
            r2_valid  <= 1'b0;
            r3_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_diff  <= 16'h0000;
        end else if (w_adv) begin
            r1_valid  <= in_valid;
            r2_valid  <= r1_valid;
            r3_valid  <= r2_valid;
            out_valid <= r3_valid;
            if (r3_valid) out_diff <= w4_res;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_float_sub16_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_float_sub16_pipe                                        |
// | Description : Self-checking bench for float_sub16_pipe. Expected values  |
// |               come from an exact-arithmetic reference of half-precision  |
// |               subtraction (FLOAT_SUB16_RNE_EN selects its rounding).     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_float_sub16_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_diff;

    float_sub16_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_diff  (out_diff)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_bad = 0;
    int          n_pop = 0;
    logic [15:0] exp_q[$];
    logic        last_in_fire;
    logic        g_use = 1'b0;
    logic [15:0] g_exp;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Real value scaled by 2^24 so every normal half is an exact integer.
    function automatic longint fval(input logic [15:0] x);
        longint m;
        if (x[14:10] == 5'd0) return 0;
        m = longint'({1'b1, x[9:0]}) << (int'(x[14:10]) - 1);
        return x[15] ? -m : m;
    endfunction

    function automatic logic [15:0] ref_sub(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] bn;
        logic        a_nan, b_nan, a_inf, b_inf, s;
        longint      d, m, sig, rem, half;
        int          p, e, sh;
        bn    = {~b[15], b[14:0]};
        a_nan = (a[14:10] == 5'h1F) && (a[9:0] != 0);
        b_nan = (b[14:10] == 5'h1F) && (b[9:0] != 0);
        a_inf = (a[14:10] == 5'h1F) && (a[9:0] == 0);
        b_inf = (b[14:10] == 5'h1F) && (b[9:0] == 0);
        if (a_nan || b_nan) return 16'h7E00;
        if (a_inf && b_inf) return (a[15] == bn[15]) ? {a[15], 15'h7C00} : 16'h7E00;
        if (a_inf) return {a[15], 15'h7C00};
        if (b_inf) return {bn[15], 15'h7C00};
        d = fval(a) + fval(bn);
        if (d == 0) return 16'h0000;
        s = (d < 0);
        m = s ? -d : d;
        p = 0;
        for (int i = 0; i < 48; i++) if (m[i]) p = i;
        e = p - 9;
        if (e <= 0) return 16'h0000;
        if (e >= 31) return {s, 15'h7C00};
        sh  = p - 10;
        sig = m >> sh;
        rem = m - (sig << sh);
`ifdef FLOAT_SUB16_RNE_EN
        if (sh > 0) begin
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && sig[0])) sig++;
        end
        if (sig == 2048) begin
            sig = 1024;
            e++;
        end
        if (e >= 31) return {s, 15'h7C00};
`else
        half = rem;
`endif
        return {s, e[4:0], sig[9:0]};
    endfunction

    // One clock: record handshakes before the edge, check after it.
    task automatic tick();
        logic in_fire, out_fire, stall_now, rst_now;
        logic [15:0] a_s, b_s, d_s, e_v;
        #3;
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        stall_now = out_valid && !out_ready;
        rst_now   = rst;
        d_s = out_diff; a_s = in_a; b_s = in_b;
        chk("in_ready", {15'd0, in_ready}, {15'd0, !stall_now});
        @(posedge clk);
        #1;
        last_in_fire = in_fire && !rst_now;
        if (rst_now) begin
            exp_q.delete();
        end else begin
            if (out_fire) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", d_s, 16'hxxxx);
                end else begin
                    e_v = exp_q.pop_front();
                    n_pop++;
                    chk("out_diff", d_s, e_v);
                end
            end
            if (in_fire) exp_q.push_back(g_use ? g_exp : ref_sub(a_s, b_s));
            if (stall_now) begin
                chk("stall_valid", {15'd0, out_valid}, 16'd1);
                chk("stall_hold", out_diff, d_s);
            end
        end
    endtask

    task automatic drain();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
        chk("drain_empty", 16'(exp_q.size()), 16'd0);
    endtask

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic use_lit, input logic [15:0] lit);
        in_a = a; in_b = b; in_valid = 1'b1; out_ready = 1'b1;
        g_use = use_lit; g_exp = lit;
        last_in_fire = 1'b0;
        for (int k = 0; k < 20 && !last_in_fire; k++) tick();
        chk("send_accept", {15'd0, last_in_fire}, 16'd1);
        g_use = 1'b0; in_valid = 1'b0;
    endtask

    // Accept one op, confirm it appears exactly three edges later.
    task automatic lat_check(input logic [15:0] a, input logic [15:0] b, input logic [15:0] e);
        send(a, b, 1'b1, e);
        tick(); chk("lat_n1", {15'd0, out_valid}, 16'd0);
        tick(); chk("lat_n2", {15'd0, out_valid}, 16'd0);
        tick(); chk("lat_n3", {15'd0, out_valid}, 16'd1);
        chk("lat_diff", out_diff, e);
        tick();
    endtask

    logic [15:0] ra, rb, bp_a[5], bp_b[5];
    logic        pend;
    int          sent, pops0;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_a = 16'h0; in_b = 16'h0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_out_valid", {15'd0, out_valid}, 16'd0);
        chk("rst_out_diff", out_diff, 16'h0000);
        chk("rst_in_ready", {15'd0, in_ready}, 16'd1);

        lat_check(16'h4200, 16'h3C00, 16'h4000);

        send(16'h3C00, 16'h3C00, 1'b1, 16'h0000);
        send(16'h3C00, 16'hBC00, 1'b1, 16'h4000);
        send(16'h3C00, 16'h4000, 1'b1, 16'hBC00);
        send(16'h7E00, 16'h3C00, 1'b1, 16'h7E00);
        send(16'h7C00, 16'h7C00, 1'b1, 16'h7E00);
        send(16'h7C00, 16'h3C00, 1'b1, 16'h7C00);
        send(16'h7BFF, 16'hFBFF, 1'b1, 16'h7C00);
        send(16'h0001, 16'h0000, 1'b1, 16'h0000);
        // 1.0 - 2^-11*(1+2^-10): exact result lies just below 0x3BFF.
`ifdef FLOAT_SUB16_RNE_EN
        send(16'h3C00, 16'h1001, 1'b1, 16'h3BFF);
`else
        send(16'h3C00, 16'h1001, 1'b1, 16'h3BFE);
`endif
        drain();

        // Backpressure: five back-to-back pairs, sink refuses three cycles.
        bp_a = '{16'h4500, 16'hC200, 16'h3555, 16'h5A00, 16'h0400};
        bp_b = '{16'h3C00, 16'h4100, 16'hB555, 16'h5A00, 16'h8400};
        pops0 = n_pop; sent = 0;
        for (int c = 0; c < 40 && (sent < 5 || exp_q.size() != 0); c++) begin
            in_valid  = (sent < 5);
            in_a      = bp_a[sent < 5 ? sent : 4];
            in_b      = bp_b[sent < 5 ? sent : 4];
            out_ready = !(c >= 4 && c <= 6);
            tick();
            if (last_in_fire) sent++;
        end
        in_valid = 1'b0;
        chk("bp_delivered", 16'(n_pop - pops0), 16'd5);

        // Reset with three ops in flight; none may surface afterwards.
        out_ready = 1'b1;
        send(16'h4000, 16'h3C00, 1'b0, 16'h0);
        in_a = 16'h4400; in_b = 16'h3C00; in_valid = 1'b1; tick();
        in_a = 16'h4800; in_b = 16'h3C00; tick();
        in_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
        chk("mid_rst_valid", {15'd0, out_valid}, 16'd0);
        chk("mid_rst_diff", out_diff, 16'h0000);
        pops0 = n_pop;
        for (int k = 0; k < 8; k++) tick();
        chk("mid_rst_silent", 16'(n_pop - pops0), 16'd0);
        lat_check(16'h4200, 16'h3C00, 16'h4000);

        // Random traffic with random backpressure.
        pend = 1'b0;
        for (int c = 0; c < 700; c++) begin
            if (!pend) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                case ($urandom_range(0, 3))
                    0: ;
                    1: begin
                        ra[14:10] = 5'($urandom_range(1, 30));
                        rb[14:10] = 5'($urandom_range(1, 30));
                    end
                    2: begin
                        ra[14:10] = 5'($urandom_range(1, 30));
                        rb[14:10] = ra[14:10];
                    end
                    default: begin
                        ra[14:10] = 5'($urandom_range(1, 30));
                        rb = ($urandom_range(0, 1) != 0) ? ra : {~ra[15], ra[14:0]};
                        rb[1:0] = 2'($urandom);
                    end
                endcase
                pend = 1'b1;
            end
            in_a = ra; in_b = rb;
            in_valid  = ($urandom_range(0, 4) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (last_in_fire) pend = 1'b0;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
